// File: rtl/day_cycle_if.sv
// day_cycle_if: bus between the VGA timing side and the day/night sequencer.
// Signals:
//   vsync      - vertical sync from the VGA timing generator (driven by master)
//   enable     - 1 = cycle runs, 0 = pause (driven by master)
//   restart    - synchronous pulse back to NIGHT start (driven by master)
//   fade_level - 8-bit fade level to sprite/sky stages (driven by slave)
//   phase      - 0=NIGHT 1=RAMP 2=HOLD 3=FALL (driven by slave)
//   frame_tick - one-clk pulse per counted frame (driven by slave)
interface day_cycle_if;
  logic       vsync;
  logic       enable;
  logic       restart;
  logic [7:0] fade_level;
  logic [1:0] phase;
  logic       frame_tick;
  modport master (output vsync, enable, restart, input fade_level, phase, frame_tick);
  modport slave  (input vsync, enable, restart, output fade_level, phase, frame_tick);
endinterface

// File: rtl/day_cycle_seq.sv
// day_cycle_seq: frame-rate day/night sequencer producing fade_level from vsync edges.
// Ports:
//   clk   - pixel clock, same domain as vsync
//   rst_n - asynchronous active-low reset
//   bus   - day_cycle_if.slave (vsync, enable, restart in; fade_level, phase, frame_tick out)
// Optional feature: define DAY_CYCLE_PINGPONG_EN to add the FALL phase (symmetric sunset);
// without it HOLD returns straight to NIGHT with fade_level forced to 0.
module day_cycle_seq #(
  parameter int unsigned NIGHT_FRAMES     = 120,
  parameter int unsigned STEP_FRAMES      = 4,
  parameter int unsigned HOLD_FRAMES      = 240,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  day_cycle_if.slave bus
);
  localparam logic [15:0] N_EFF = (NIGHT_FRAMES == 0) ? 16'd1 : 16'(NIGHT_FRAMES);
  localparam logic [15:0] S_EFF = (STEP_FRAMES  == 0) ? 16'd1 : 16'(STEP_FRAMES);
  localparam logic [15:0] H_EFF = (HOLD_FRAMES  == 0) ? 16'd1 : 16'(HOLD_FRAMES);
  localparam logic        V_IDLE = VSYNC_ACTIVE_LOW;
  typedef enum logic [1:0] {NIGHT = 2'd0, RAMP = 2'd1, HOLD = 2'd2, FALL = 2'd3} state_t;
  state_t      state_q, state_n;
  logic [7:0]  fade_q, fade_n;
  logic [15:0] cnt_q, cnt_n, cnt_inc;
  logic        vsync_q, tick_q, tick, v_edge;
  // Polarity-normalised edge: previous sample idle, current sample active.
  assign v_edge  = (vsync_q == V_IDLE) & (bus.vsync != V_IDLE);
  assign tick    = v_edge & bus.enable & ~bus.restart;
  assign cnt_inc = cnt_q + 16'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NIGHT;
      fade_q  <= 8'd0;
      cnt_q   <= 16'd0;
      vsync_q <= V_IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      fade_q  <= fade_n;
      cnt_q   <= cnt_n;
      vsync_q <= bus.vsync;
      tick_q  <= tick;
    end
  end
  always_comb begin
    state_n = state_q;
    fade_n  = fade_q;
    cnt_n   = cnt_q;
    if (bus.restart) begin
      state_n = NIGHT;
      fade_n  = 8'd0;
      cnt_n   = 16'd0;
    end else if (tick) begin
      case (state_q)
        NIGHT: begin
          fade_n = 8'd0;
          cnt_n  = (cnt_inc >= N_EFF) ? 16'd0 : cnt_inc;
          state_n = (cnt_inc >= N_EFF) ? RAMP : NIGHT;
        end
        RAMP: begin
          cnt_n = (cnt_inc >= S_EFF) ? 16'd0 : cnt_inc;
          if (cnt_inc >= S_EFF) begin
            fade_n  = fade_q + 8'd1;
            state_n = (fade_q == 8'd254) ? HOLD : RAMP;
          end
        end
        HOLD: begin
          cnt_n = (cnt_inc >= H_EFF) ? 16'd0 : cnt_inc;
          if (cnt_inc >= H_EFF) begin
`ifdef DAY_CYCLE_PINGPONG_EN
            // Leaving HOLD is the first sunset step, mirroring the ramp's last step into HOLD.
            state_n = FALL;
            fade_n  = 8'd254;
`else
            state_n = NIGHT;
            fade_n  = 8'd0;
`endif
          end
        end
`ifdef DAY_CYCLE_PINGPONG_EN
        FALL: begin
          cnt_n = (cnt_inc >= S_EFF) ? 16'd0 : cnt_inc;
          if (cnt_inc >= S_EFF) begin
            fade_n  = fade_q - 8'd1;
            state_n = (fade_q == 8'd1) ? NIGHT : FALL;
          end
        end
`endif
        default: begin
          state_n = NIGHT;
          fade_n  = 8'd0;
          cnt_n   = 16'd0;
        end
      endcase
    end
  end
  assign bus.fade_level = fade_q;
  assign bus.phase      = state_q;
  assign bus.frame_tick = tick_q;
endmodule
